// File: rtl/leitor_matriz_pkg.sv
// ============================================================================
// Module   : leitor_matriz_pkg
// Brief    : Shared sizes, column classification and helpers for the
//            5x7 LED matrix scan receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package leitor_matriz_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_LINS = 7;

  typedef enum logic [1:0] {
    COL_VALIDA  = 2'd0,
    COL_APAGADA = 2'd1,
    COL_ILEGAL  = 2'd2
  } col_class_t;

  function automatic logic [2:0] onehot_idx(input logic [NUM_COLS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/leitor_coluna.sv
// ============================================================================
// Module   : leitor_coluna
// Brief    : Registers the scan lines, normalises polarity, classifies the
//            column pattern and strobes a capture once per settled dwell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leitor_coluna
  import leitor_matriz_pkg::*;
#(
  parameter int SETTLE     = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_COLS-1:0] col,
  input  logic [NUM_LINS-1:0] lin,
  output col_class_t          classe,
  output logic                captura,
  output logic [2:0]          indice,
  output logic [NUM_LINS-1:0] linha
);

  localparam int                   c_cw     = $clog2(SETTLE + 1);
  localparam logic [c_cw-1:0]      c_settle = c_cw'(SETTLE);
  localparam logic [NUM_COLS-1:0]  c_pol_c  = {NUM_COLS{ACTIVE_LOW}};
  localparam logic [NUM_LINS-1:0]  c_pol_l  = {NUM_LINS{ACTIVE_LOW}};

  logic [NUM_COLS-1:0] r_col;
  logic [NUM_LINS-1:0] r_lin;
  logic [c_cw-1:0]     r_cnt;
  logic [c_cw-1:0]     w_cnt_next;
  logic [2:0]          r_idx;
  logic [2:0]          w_idx;
  logic                w_onehot;
  logic                w_mesma;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_col <= '0;
      r_lin <= '0;
    end else begin
      r_col <= col ^ c_pol_c;
      r_lin <= lin ^ c_pol_l;
    end
  end

  assign w_onehot = (r_col != '0) && ((r_col & (r_col - 1'b1)) == '0);
  assign w_idx    = onehot_idx(r_col);
  // r_cnt is non-zero only if the previous registered cycle was a valid column
  assign w_mesma  = (r_cnt != '0) && (w_idx == r_idx);

  always_comb begin
    classe     = COL_ILEGAL;
    w_cnt_next = '0;
    captura    = 1'b0;
    if (r_col == '0) begin
      classe = COL_APAGADA;
    end else if (w_onehot) begin
      classe = COL_VALIDA;
      if (!w_mesma)               w_cnt_next = c_cw'(1);
      else if (r_cnt == c_settle) w_cnt_next = r_cnt;
      else                        w_cnt_next = r_cnt + c_cw'(1);
      captura = (w_cnt_next == c_settle) && !(w_mesma && (r_cnt == c_settle));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (classe == COL_VALIDA) r_idx <= w_idx;
    end
  end

  assign indice = w_idx;
  assign linha  = r_lin;

endmodule

`default_nettype wire

// File: rtl/leitor_matriz.sv
// ============================================================================
// Module   : leitor_matriz
// Brief    : Rebuilds the displayed 5x7 frame from the scan lines, flags scan
//            faults, blank matrix and frame stability.
//            Optional stability tracking: define LEITOR_MATRIZ_STABLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leitor_matriz
  import leitor_matriz_pkg::*;
#(
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 3,
  parameter int BLANK_TIMEOUT = 1024,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_COLS-1:0] col,
  input  logic [NUM_LINS-1:0] lin,
  output logic [NUM_LINS-1:0] mapa0,
  output logic [NUM_LINS-1:0] mapa1,
  output logic [NUM_LINS-1:0] mapa2,
  output logic [NUM_LINS-1:0] mapa3,
  output logic [NUM_LINS-1:0] mapa4,
  output logic                quadro_ok,
  output logic                quadro_mudou,
  output logic                estavel,
  output logic                apagado,
  output logic                erro_varredura
);

  if (SETTLE < 1 || STABLE_FRAMES < 1 || BLANK_TIMEOUT < 1) begin : g_param_check
    $error("leitor_matriz: SETTLE, STABLE_FRAMES and BLANK_TIMEOUT must be >= 1");
  end

  localparam int              c_bw      = $clog2(BLANK_TIMEOUT + 1);
  localparam logic [c_bw-1:0] c_timeout = c_bw'(BLANK_TIMEOUT);

  col_class_t                               w_classe;
  logic                                     w_captura;
  logic [2:0]                               w_indice;
  logic [NUM_LINS-1:0]                      w_linha;
  logic [NUM_COLS-1:0]                      w_cap_mask;
  logic [NUM_COLS-1:0][NUM_LINS-1:0]        r_shadow;
  logic [NUM_COLS-1:0][NUM_LINS-1:0]        r_mapa;
  logic [NUM_COLS-1:0]                      r_visto;
  logic [c_bw-1:0]                          r_blank_cnt;
  logic [c_bw-1:0]                          w_blank_next;
  logic                                     w_timeout;
  logic                                     w_commit;
  logic                                     r_ok;
  logic                                     r_apagado;

  leitor_coluna #(
    .SETTLE     (SETTLE),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_coluna (
    .clock   (clock),
    .reset_n (reset_n),
    .col     (col),
    .lin     (lin),
    .classe  (w_classe),
    .captura (w_captura),
    .indice  (w_indice),
    .linha   (w_linha)
  );

  always_comb begin
    w_blank_next = r_blank_cnt;
    if (w_classe == COL_VALIDA) begin
      w_blank_next = '0;
    end else if (w_classe == COL_APAGADA && r_blank_cnt != c_timeout) begin
      w_blank_next = r_blank_cnt + c_bw'(1);
    end
  end

  assign w_timeout  = (w_blank_next == c_timeout);
  // a blank timeout suppresses a commit that lands in the same cycle
  assign w_commit   = (r_visto == '1) && !w_timeout;
  assign w_cap_mask = w_captura ? (NUM_COLS'(1) << w_indice) : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_shadow    <= '0;
      r_mapa      <= '0;
      r_visto     <= '0;
      r_blank_cnt <= '0;
      r_ok        <= 1'b0;
      r_apagado   <= 1'b0;
    end else begin
      r_blank_cnt <= w_blank_next;
      r_apagado   <= w_timeout;
      r_ok        <= w_commit;
      for (int i = 0; i < NUM_COLS; i++) begin
        if (w_captura && (w_indice == 3'(i))) r_shadow[i] <= w_linha;
      end
      if (w_timeout)     r_mapa <= '0;
      else if (w_commit) r_mapa <= r_shadow;
      if (w_timeout || w_classe == COL_ILEGAL) r_visto <= '0;
      else r_visto <= ((r_visto == '1) ? '0 : r_visto) | w_cap_mask;
    end
  end

`ifdef LEITOR_MATRIZ_STABLE_EN
  localparam int              c_sw   = $clog2(STABLE_FRAMES + 1);
  localparam logic [c_sw-1:0] c_stab = c_sw'(STABLE_FRAMES);

  logic [c_sw-1:0] r_stab_cnt;
  logic [c_sw-1:0] w_stab_next;
  logic            w_mudou;
  logic            r_mudou;
  logic            r_estavel;

  // a zero stable count marks the first commit after reset or blank
  always_comb begin
    w_mudou     = w_commit && ((r_stab_cnt == '0) || (r_shadow != r_mapa));
    w_stab_next = r_stab_cnt;
    if (w_timeout)                                 w_stab_next = '0;
    else if (w_mudou)                              w_stab_next = c_sw'(1);
    else if (w_commit && r_stab_cnt != c_stab)     w_stab_next = r_stab_cnt + c_sw'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stab_cnt <= '0;
      r_mudou    <= 1'b0;
      r_estavel  <= 1'b0;
    end else begin
      r_stab_cnt <= w_stab_next;
      r_mudou    <= w_mudou;
      r_estavel  <= (w_stab_next == c_stab);
    end
  end

  assign quadro_mudou = r_mudou;
  assign estavel      = r_estavel;
`else
  assign quadro_mudou = 1'b0;
  assign estavel      = 1'b0;
`endif

  assign mapa0          = r_mapa[0];
  assign mapa1          = r_mapa[1];
  assign mapa2          = r_mapa[2];
  assign mapa3          = r_mapa[3];
  assign mapa4          = r_mapa[4];
  assign quadro_ok      = r_ok;
  assign apagado        = r_apagado;
  assign erro_varredura = (w_classe == COL_ILEGAL);

endmodule

`default_nettype wire
